// File: rtl/ibex_csr_access_initiator.sv
// Debug-side CSR access initiator: turns abstract read/write/set/clear commands
// into single-cycle CSR-file accesses, with optional write-verify readback.
module ibex_csr_access_initiator #(
  parameter bit VerifyEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        debug_mode_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [11:0] req_addr_i,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_verify_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_mismatch_o,
  output logic        csr_access_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic [1:0]  csr_op_o,
  output logic        csr_op_en_o,
  input  logic [31:0] csr_rdata_i,
  input  logic        illegal_csr_insn_i
);

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    VERIFY = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e      state_q;
  logic [11:0] addr_q;
  csr_op_e     op_q;
  logic [31:0] wdata_q;
  logic        verify_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        mismatch_q;
  logic        rsp_valid_q;
  logic [31:0] expected;
  logic        verify_next;

  // Value the CSR should hold after the committed op, built from the old value.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    expected = wdata_q;
    unique case (op_q)
      CSR_OP_SET:   expected = rdata_q | wdata_q;
      CSR_OP_CLEAR: expected = rdata_q & ~wdata_q;
      default:      expected = wdata_q;
    endcase
  end

  assign verify_next = VerifyEn && verify_q && (op_q != CSR_OP_READ) && !illegal_csr_insn_i;

  // NOTE: state uses non-blocking assignments and an asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      op_q        <= CSR_OP_READ;
      wdata_q     <= '0;
      verify_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mismatch_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q   <= req_addr_i;
            op_q     <= csr_op_e'(req_op_i);
            wdata_q  <= req_wdata_i;
            verify_q <= req_verify_i;
            if (debug_mode_i) begin
              state_q <= ACCESS;
            end else begin
              rdata_q     <= '0;
              err_q       <= 1'b1;
              mismatch_q  <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        ACCESS: begin
          mismatch_q <= 1'b0;
          if (debug_mode_i) begin
            rdata_q <= csr_rdata_i;
            err_q   <= illegal_csr_insn_i;
            if (verify_next) begin
              state_q <= VERIFY;
            end else begin
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end else begin
            rdata_q     <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        VERIFY: begin
          // Mismatch is informational only: WARL fields and counters differ legitimately.
          mismatch_q  <= debug_mode_i && (csr_rdata_i != expected);
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // CSR bus is held at zero/READ whenever no access is in flight.
  always_comb begin
    csr_access_o = 1'b0;
    csr_op_en_o  = 1'b0;
    csr_op_o     = CSR_OP_READ;
    csr_addr_o   = '0;
    csr_wdata_o  = '0;
    if (debug_mode_i) begin
      if (state_q == ACCESS) begin
        csr_access_o = 1'b1;
        csr_op_en_o  = 1'b1;
        csr_op_o     = op_q;
        csr_addr_o   = addr_q;
        csr_wdata_o  = wdata_q;
      end else if (state_q == VERIFY) begin
        csr_access_o = 1'b1;
        csr_addr_o   = addr_q;
      end
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rdata_q;
  assign rsp_err_o      = err_q;
  assign rsp_mismatch_o = VerifyEn ? mismatch_q : 1'b0;

endmodule
